// File: rtl/datapath_controller.sv
// datapath_controller: multi-cycle sequencer for the 16-bit register-bus datapath.
// Fetches by pulsing increment, latches the 8-bit instruction, then steps the
// one-hot bus selects and ALU select until the instruction retires.
//
// Ports:
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   run          in   1   level; keep fetching/executing while high
//   instruction  in   8   [7:6] op, [5:3] x, [2:0] y/imm
//   rout         out  16  one-hot bus-driver select (R0..R7 = bits 0..7)
//   ren          out  16  one-hot bus-load select, 0 = none
//   addxor       out  1   ALU op (0 add, 1 xor); also 1 during LDI
//   increment    out  1   one-cycle program-counter advance pulse
//   done         out  1   one-cycle pulse in an instruction's final step
//   busy         out  1   high outside IDLE
//   instr_count  out  16  retired-instruction count, wraps
module datapath_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  instruction,
  output logic [15:0] rout,
  output logic [15:0] ren,
  output logic        addxor,
  output logic        increment,
  output logic        done,
  output logic        busy,
  output logic [15:0] instr_count
);

  localparam logic [15:0] A_SEL     = 16'h0200;
  localparam logic [15:0] G_SEL     = 16'h0100;
  localparam logic [15:0] EXT_SEL   = 16'h0400;
  localparam logic [15:0] IDLE_ROUT = 16'h8000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_T1     = 3'd4;
  localparam logic [2:0] ST_T2     = 3'd5;
  localparam logic [2:0] ST_T3     = 3'd6;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;

  logic [2:0]  state_q, state_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] rout_d, ren_d, count_d;
  logic        addxor_d, increment_d, done_d, busy_d;
  logic        retire;

  // One-hot register select for R0..R7.
  function automatic logic [15:0] reg_sel(input logic [2:0] r);
    return 16'(1) << r;
  endfunction

  // State, IR and all outputs are registered together so every output holds
  // its per-state value for the whole cycle spent in that state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ir_q        <= 8'h00;
      rout        <= IDLE_ROUT;
      ren         <= 16'h0000;
      addxor      <= 1'b0;
      increment   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      rout        <= rout_d;
      ren         <= ren_d;
      addxor      <= addxor_d;
      increment   <= increment_d;
      done        <= done_d;
      busy        <= busy_d;
      instr_count <= count_d;
    end
  end

  // Next state, then the outputs belonging to that next state. T1 outputs
  // are decoded from ir_d, which is the instruction being latched in DECODE.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    rout_d      = IDLE_ROUT;
    ren_d       = 16'h0000;
    addxor_d    = 1'b0;
    increment_d = 1'b0;
    done_d      = 1'b0;
    retire      = 1'b0;

    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = instruction;
        state_d = ST_T1;
      end
      ST_T1: begin
        if (ir_q[7]) state_d = ST_T2;
        else         retire  = 1'b1;
      end
      ST_T2:   state_d = ST_T3;
      ST_T3:   retire  = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    count_d = retire ? instr_count + 16'd1 : instr_count;

    case (state_d)
      ST_FETCH: increment_d = 1'b1;
      ST_T1: begin
        if (ir_d[7:6] == OP_MV) begin
          rout_d = reg_sel(ir_d[2:0]);
          ren_d  = reg_sel(ir_d[5:3]);
          done_d = 1'b1;
        end else if (ir_d[7:6] == OP_LDI) begin
          addxor_d = 1'b1;
          rout_d   = EXT_SEL;
          ren_d    = reg_sel(ir_d[5:3]);
          done_d   = 1'b1;
        end else begin
          rout_d = reg_sel(ir_d[5:3]);
          ren_d  = A_SEL;
        end
      end
      ST_T2: begin
        rout_d   = reg_sel(ir_d[2:0]);
        ren_d    = G_SEL;
        addxor_d = ir_d[6];
      end
      ST_T3: begin
        rout_d = G_SEL;
        ren_d  = reg_sel(ir_d[5:3]);
        done_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: walks LDI, ADD, XOR and MV
// instructions cycle by cycle against hand-computed per-state outputs,
// plus run deassertion, counter wrap and asynchronous reset mid-instruction.
module tb_datapath_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  instruction;
  logic [15:0] rout;
  logic [15:0] ren;
  logic        addxor;
  logic        increment;
  logic        done;
  logic        busy;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;

  datapath_controller dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .rout        (rout),
    .ren         (ren),
    .addxor      (addxor),
    .increment   (increment),
    .done        (done),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and compare every control output at the falling edge.
  task automatic step(input string tag, input logic [15:0] e_rout, input logic [15:0] e_ren,
                      input logic e_add, input logic e_inc, input logic e_done,
                      input logic e_busy);
    @(negedge clock);
    check({tag, ".rout"}, rout, e_rout);
    check({tag, ".ren"}, ren, e_ren);
    check({tag, ".addxor"}, 16'(addxor), 16'(e_add));
    check({tag, ".increment"}, 16'(increment), 16'(e_inc));
    check({tag, ".done"}, 16'(done), 16'(e_done));
    check({tag, ".busy"}, 16'(busy), 16'(e_busy));
  endtask

  // FETCH, WAIT, DECODE are identical for every instruction.
  task automatic front(input string tag);
    step({tag, ".fetch"},  16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    step({tag, ".wait"},   16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step({tag, ".decode"}, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    run         = 1'b0;
    instruction = 8'h00;

    // Reset state
    @(negedge clock);
    check("rst.rout", rout, 16'h8000);
    check("rst.ren", ren, 16'h0000);
    check("rst.inc", 16'(increment), 16'h0000);
    check("rst.busy", 16'(busy), 16'h0000);
    check("rst.count", instr_count, 16'h0000);

    // LDI R0, 1
    reset       = 1'b0;
    run         = 1'b1;
    instruction = 8'b01_000_001;
    front("ldi");
    step("ldi.t1", 16'h0400, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1);
    check("ldi.count", instr_count, 16'd0);
    instruction = 8'b10_000_001;

    // ADD R0, R1 back-to-back
    front("add");
    check("add.count", instr_count, 16'd1);
    step("add.t1", 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add.t2", 16'h0002, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add.t3", 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    instruction = 8'b11_010_011;

    // XOR R2, R3
    front("xor");
    check("xor.count", instr_count, 16'd2);
    step("xor.t1", 16'h0004, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1);
    step("xor.t2", 16'h0008, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);
    step("xor.t3", 16'h0100, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b1);
    instruction = 8'b00_101_010;

    // MV R5, R2
    front("mv52");
    step("mv52.t1", 16'h0004, 16'h0020, 1'b0, 1'b0, 1'b1, 1'b1);
    instruction = 8'h00;

    // MV R0, R0 no-op still retires
    front("mv00");
    check("mv00.count", instr_count, 16'd4);
    step("mv00.t1", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    instruction = 8'b10_000_001;

    // ADD with run dropped during T1: completes, then IDLE with no fetch
    front("addstop");
    check("addstop.count", instr_count, 16'd5);
    step("addstop.t1", 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1);
    run = 1'b0;
    step("addstop.t2", 16'h0002, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
    step("addstop.t3", 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("idle", 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle.count", instr_count, 16'd6);

    // Counter wrap: preload 16'hFFFF, then one more retire
    force dut.instr_count = 16'hFFFF;
    #1;
    release dut.instr_count;
    check("wrap.preload", instr_count, 16'hFFFF);
    run = 1'b1;
    front("wrap");
    step("wrap.t1", 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1);
    step("wrap.t2", 16'h0002, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
    step("wrap.t3", 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    check("wrap.before", instr_count, 16'hFFFF);

    // Next ADD, aborted by reset mid-T2 (between clock edges)
    front("abort");
    check("wrap.after", instr_count, 16'h0000);
    step("abort.t1", 16'h0001, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1);
    step("abort.t2", 16'h0002, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("abort.rout", rout, 16'h8000);
    check("abort.ren", ren, 16'h0000);
    check("abort.inc", 16'(increment), 16'h0000);
    check("abort.busy", 16'(busy), 16'h0000);
    check("abort.done", 16'(done), 16'h0000);
    check("abort.count", instr_count, 16'h0000);
    step("abort.hold", 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    run   = 1'b0;
    step("post", 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
